sd_block_server: RTL and testbench
==================================

SD_BLOCK_SERVER -- requirements
Module: sd_block_server

Interface
REQ-001 SHALL have parameter MAX_LBA, default 455, number of valid 512-byte blocks (35 tracks x 13).
REQ-002 SHALL have parameter MEM_AW, default 23, backing-memory byte address width.
REQ-003 SHALL have ports: clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-005 SHALL have ports: sd_lba  in  32  block number of the request.
REQ-006 SHALL have ports: sd_rd / sd_wr  in  1 each  level block read/write requests from client.
REQ-007 SHALL have ports: sd_ack  out  1  transfer in progress.
REQ-008 SHALL have ports: sd_buff_addr  out  9  byte index in block; sd_buff_dout  out  8  read data to client; sd_buff_wr  out  1  read-data strobe; sd_buff_din  in  8  write data from client.
REQ-009 SHALL have ports: mem_addr  out  MEM_AW; mem_rd / mem_wr  out  1; mem_dout  out  8  write data; mem_din  in  8  read data; mem_ready  in  1  access complete.
REQ-010 SHALL have ports: err  out  1  one-cycle error pulse.

Function
REQ-011 SHALL use states IDLE, RD_FETCH, RD_PUT, WR_ADDR, WR_SAMPLE, WR_STORE, DONE.
REQ-012 IDLE: sd_rd=1 -> latch sd_lba, index=0, sd_ack=1 next cycle, go RD_FETCH; else sd_wr=1 -> same, go WR_ADDR; sd_rd and sd_wr both 1 -> read served first, write stays pending.
REQ-013 mem_addr SHALL equal {lba[MEM_AW-10:0], index}; upper LBA bits ignored for addressing.
REQ-014 RD_FETCH: hold mem_rd=1 until mem_ready=1; capture mem_din that cycle; go RD_PUT.
REQ-015 RD_PUT: drive sd_buff_addr=index, sd_buff_dout=captured byte, sd_buff_wr=1 for exactly one cycle; index 511 -> DONE, else index+1, RD_FETCH.
REQ-016 WR_ADDR: drive sd_buff_addr=index; WR_SAMPLE (next cycle, address unchanged): capture sd_buff_din (client RAM has 1-cycle read latency).
REQ-017 WR_STORE: hold mem_wr=1, mem_dout=captured byte until mem_ready=1; index 511 -> DONE, else index+1, WR_ADDR.
REQ-018 DONE: sd_ack=0 for at least one cycle, then IDLE; a request asserted during DONE SHALL be accepted from IDLE only.
REQ-019 Min rate: 2 cycles/byte read, 3 cycles/byte write; mem_ready stuck 0 stalls indefinitely, no timeout.
REQ-020 sd_lba >= MAX_LBA: full 512-byte handshake still performed, no mem_rd/mem_wr issued, read bytes = 8'h00, write bytes discarded, err=1 in DONE cycle.
REQ-021 sd_lba, sd_rd, sd_wr changes while sd_ack=1 SHALL be ignored.
REQ-022 sd_buff_wr SHALL never assert while sd_ack=0; mem_rd and mem_wr SHALL never be asserted together.

Reset
REQ-023 reset SHALL immediately force IDLE, sd_ack=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, err=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0, mem_dout=0.
REQ-024 Reset mid-transfer SHALL abandon the block; a still-asserted request after release SHALL restart from index 0.

Configuration
REQ-025 Macro SDSRV_WRITE_PROTECT_EN SHALL, when defined, add input port wp (1 bit); with wp=1 at write acceptance the block SHALL run the full write handshake, issue no mem_wr, and pulse err in DONE.
REQ-026 Without SDSRV_WRITE_PROTECT_EN, no wp port SHALL exist and writes follow REQ-016/017 unchanged.

Verification
REQ-027 sd_rd=1, sd_lba=2, mem_ready tied 1, memory byte n = n[7:0] -> 512 sd_buff_wr pulses, addr 0..511, data 00..FF twice, mem_addr 0x400..0x5FF, sd_ack falls, err=0.
REQ-028 sd_wr=1, sd_lba=13, client RAM byte n = ~n -> mem_wr at 0x1A00..0x1BFF with data ~n, sd_buff_din sampled one cycle after sd_buff_addr.
REQ-029 sd_lba=455 read -> 512 bytes of 00, no mem_rd, err pulse 1 cycle at DONE.
REQ-030 sd_rd and sd_wr both 1, lba 0 -> read completes, sd_ack low >=1 cycle, then write of lba 0 accepted.
REQ-031 reset pulsed at byte 100 of read with mem_ready random -> all outputs 0 asynchronously, sd_rd held -> new transfer restarts at index 0.
REQ-032 SDSRV_WRITE_PROTECT_EN defined, wp=1, write lba 5 -> 512 sd_buff_addr steps, zero mem_wr, err=1; wp=0 -> 512 mem_wr.

Source files
------------

// File: rtl/sd_block_server.sv
// Serves 512-byte blocks between a client sector buffer and a byte-wide backing memory.
// Optional macro SDSRV_WRITE_PROTECT_EN adds a wp input that suppresses memory writes.
module sd_block_server #(
  parameter int MAX_LBA = 455,
  parameter int MEM_AW  = 23
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SDSRV_WRITE_PROTECT_EN
  input  logic              wp,
`endif
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, RD_FETCH, RD_PUT, WR_ADDR, WR_SAMPLE, WR_STORE, DONE
  } state_t;

  state_t            r_state;
  logic [MEM_AW-10:0] r_lba;
  logic [8:0]        r_index;
  logic              r_skip;

  logic              w_lba_oob;
  logic              w_wp;
  logic              w_last;
  logic [8:0]        w_index_inc;

  assign w_lba_oob   = (sd_lba >= 32'(MAX_LBA));
  assign w_last      = (r_index == 9'd511);
  assign w_index_inc = r_index + 9'd1;

`ifdef SDSRV_WRITE_PROTECT_EN
  assign w_wp = wp;
`else
  assign w_wp = 1'b0;
`endif

  // r_skip: handshake with the client runs normally, backing memory is never touched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lba        <= '0;
      r_index      <= '0;
      r_skip       <= 1'b0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_dout     <= '0;
      err          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            r_lba        <= sd_lba[MEM_AW-10:0];
            r_index      <= '0;
            sd_ack       <= 1'b1;
            sd_buff_addr <= '0;
            mem_addr     <= {sd_lba[MEM_AW-10:0], 9'd0};
            if (sd_rd) begin
              r_skip  <= w_lba_oob;
              mem_rd  <= ~w_lba_oob;
              r_state <= RD_FETCH;
            end else begin
              r_skip  <= w_lba_oob | w_wp;
              r_state <= WR_ADDR;
            end
          end
        end
        RD_FETCH: begin
          if (r_skip || mem_ready) begin
            mem_rd       <= 1'b0;
            sd_buff_dout <= r_skip ? 8'h00 : mem_din;
            sd_buff_addr <= r_index;
            sd_buff_wr   <= 1'b1;
            r_state      <= RD_PUT;
          end
        end
        RD_PUT: begin
          sd_buff_wr <= 1'b0;
          if (w_last) begin
            sd_ack  <= 1'b0;
            err     <= r_skip;
            r_state <= DONE;
          end else begin
            r_index  <= w_index_inc;
            mem_addr <= {r_lba, w_index_inc};
            mem_rd   <= ~r_skip;
            r_state  <= RD_FETCH;
          end
        end
        WR_ADDR: r_state <= WR_SAMPLE;
        // client buffer RAM returns data one cycle after the address is presented
        WR_SAMPLE: begin
          mem_dout <= sd_buff_din;
          mem_wr   <= ~r_skip;
          r_state  <= WR_STORE;
        end
        WR_STORE: begin
          if (r_skip || mem_ready) begin
            mem_wr <= 1'b0;
            if (w_last) begin
              sd_ack  <= 1'b0;
              err     <= r_skip;
              r_state <= DONE;
            end else begin
              r_index      <= w_index_inc;
              sd_buff_addr <= w_index_inc;
              mem_addr     <= {r_lba, w_index_inc};
              r_state      <= WR_ADDR;
            end
          end
        end
        DONE: begin
          err     <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_server.sv
// Bench for sd_block_server: directed block transfers plus randomized ones,
// checked against a per-block expectation built from LBA and byte index.
module tb_sd_block_server;
  localparam int MAX_LBA = 455;
  localparam int MEM_AW  = 23;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
`ifdef SDSRV_WRITE_PROTECT_EN
  logic              wp = 1'b0;
`endif
  logic [31:0]       sd_lba = '0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = '0;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din = '0;
  logic              mem_ready = 1'b0;
  logic              err;

  sd_block_server #(.MAX_LBA(MAX_LBA), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
`ifdef SDSRV_WRITE_PROTECT_EN
    .wp(wp),
`endif
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] mkey = 8'h00, mmask = 8'h00, ckey = 8'h00;
  bit         ready_rand = 1'b0;
  logic [8:0] cram_a = '0;

  logic [16:0]        rd_q[$];
  logic [MEM_AW-1:0]  ra_q[$];
  logic [MEM_AW+7:0]  wr_q[$];
  logic [8:0]         tr_q[$];
  int last_addr = -1;
  int mrd_cyc = 0, mwr_cyc = 0, err_cnt = 0, err_ack_bad = 0, inv_bad = 0;

  function automatic logic [7:0] memf(input logic [MEM_AW-1:0] a);
    return a[7:0] ^ mkey ^ (a[15:8] & mmask);
  endfunction

  function automatic logic [7:0] cramf(input logic [8:0] n);
    return ~n[7:0] ^ ckey;
  endfunction

  // backing memory and client buffer RAM (registered read) models
  always @(posedge clk) begin
    #1;
    mem_ready   = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_din     = mem_ready ? memf(mem_addr) : 8'($urandom);
    sd_buff_din = cramf(cram_a);
  end

  always @(negedge clk) begin
    cram_a = sd_buff_addr;
    if (sd_buff_wr) rd_q.push_back({sd_buff_addr, sd_buff_dout});
    if (mem_rd) begin
      mrd_cyc++;
      if (mem_ready) ra_q.push_back(mem_addr);
    end
    if (mem_wr) begin
      mwr_cyc++;
      if (mem_ready) wr_q.push_back({mem_addr, mem_dout});
    end
    if (sd_ack && int'(sd_buff_addr) != last_addr) begin
      tr_q.push_back(sd_buff_addr);
      last_addr = int'(sd_buff_addr);
    end
    if (err) begin
      err_cnt++;
      if (sd_ack) err_ack_bad++;
    end
    if ((sd_buff_wr && !sd_ack) || (mem_rd && mem_wr)) inv_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete(); ra_q.delete(); wr_q.delete(); tr_q.delete();
    last_addr = -1; mrd_cyc = 0; mwr_cyc = 0; err_cnt = 0; err_ack_bad = 0;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (sd_ack !== lvl && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_level", 32'(sd_ack), 32'(lvl));
  endtask

  task automatic chk_outs_zero();
    chk("rst_ack", 32'(sd_ack), 0);
    chk("rst_buff_wr", 32'(sd_buff_wr), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_buff_addr", 32'(sd_buff_addr), 0);
    chk("rst_buff_dout", 32'(sd_buff_dout), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
  endtask

  // expected block: byte n lives at lba*512+n (low address bits of lba only)
  task automatic check_xfer(input bit is_rd, input logic [31:0] lba, input bit skip);
    int unsigned base;
    int n;
    base = (lba % 32'd16384) * 32'd512;
    chk("trace_len", tr_q.size(), 512);
    for (int i = 0; i < tr_q.size() && i < 512; i++) chk("trace_addr", 32'(tr_q[i]), i);
    chk("err_pulses", err_cnt, 32'(skip));
    chk("err_with_ack", err_ack_bad, 0);
    if (is_rd) begin
      chk("rd_count", rd_q.size(), 512);
      for (int i = 0; i < rd_q.size() && i < 512; i++) begin
        chk("rd_addr", 32'(rd_q[i][16:8]), i);
        chk("rd_data", 32'(rd_q[i][7:0]), skip ? 32'd0 : 32'(memf(MEM_AW'(base + i))));
      end
      n = skip ? 0 : 512;
      chk("mem_rd_count", ra_q.size(), n);
      for (int i = 0; i < ra_q.size() && i < 512; i++) chk("mem_rd_addr", 32'(ra_q[i]), base + i);
      if (skip) chk("mem_rd_cycles", mrd_cyc, 0);
      chk("mem_wr_in_read", mwr_cyc, 0);
    end else begin
      n = skip ? 0 : 512;
      chk("mem_wr_count", wr_q.size(), n);
      for (int i = 0; i < wr_q.size() && i < 512; i++) begin
        chk("mem_wr_addr", 32'(wr_q[i][MEM_AW+7:8]), base + i);
        chk("mem_wr_data", 32'(wr_q[i][7:0]), 32'(cramf(9'(i))));
      end
      if (skip) chk("mem_wr_cycles", mwr_cyc, 0);
      chk("mem_rd_in_write", mrd_cyc, 0);
      chk("buff_wr_in_write", rd_q.size(), 0);
    end
  endtask

  task automatic run_xfer(input bit is_rd, input logic [31:0] lba, input bit rnd, input bit skip);
    int c;
    clear_mon();
    ready_rand = rnd;
    @(negedge clk);
    sd_lba = lba;
    if (is_rd) sd_rd = 1'b1; else sd_wr = 1'b1;
    wait_ack(1'b1, 20, c);
    // request lines and LBA wiggle while busy; they must be ignored
    repeat (40) begin
      @(negedge clk);
      sd_rd = 1'($urandom); sd_wr = 1'($urandom); sd_lba = $urandom;
    end
    sd_rd = 1'b0; sd_wr = 1'b0;
    wait_ack(1'b0, 20000, c);
    repeat (3) @(negedge clk);
    $display("[TB] %s lba=%0d skip=%0d done", is_rd ? "read" : "write", lba, skip);
    check_xfer(is_rd, lba, skip);
  endtask

  initial begin
    int c;
    logic [31:0] lba;
    bit is_rd;

    repeat (3) @(negedge clk);
    chk_outs_zero();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    mkey = 8'h00; mmask = 8'h00; ckey = 8'h00;
    run_xfer(1'b1, 32'd2, 1'b0, 1'b0);
    run_xfer(1'b0, 32'd13, 1'b0, 1'b0);
    run_xfer(1'b1, 32'd455, 1'b0, 1'b1);
    run_xfer(1'b0, 32'd1000, 1'b1, 1'b1);

    // simultaneous read and write requests
    clear_mon();
    ready_rand = 1'b0;
    @(negedge clk);
    sd_lba = 32'd0; sd_rd = 1'b1; sd_wr = 1'b1;
    wait_ack(1'b1, 20, c);
    sd_rd = 1'b0;
    wait_ack(1'b0, 20000, c);
    $display("[TB] read of simultaneous rd/wr lba=0 done");
    check_xfer(1'b1, 32'd0, 1'b0);
    clear_mon();
    wait_ack(1'b1, 20, c);
    chk("ack_low_gap", 32'(c >= 1), 1);
    sd_wr = 1'b0;
    wait_ack(1'b0, 20000, c);
    repeat (3) @(negedge clk);
    $display("[TB] pending write lba=0 done");
    check_xfer(1'b0, 32'd0, 1'b0);

    // reset in the middle of a read, request held across reset
    clear_mon();
    ready_rand = 1'b1; mkey = 8'($urandom); mmask = 8'hFF;
    @(negedge clk);
    sd_lba = 32'd37; sd_rd = 1'b1;
    c = 0;
    while (rd_q.size() < 100 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("reached_byte100", 32'(rd_q.size() >= 100), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_outs_zero();
    $display("[TB] reset asserted mid-read after %0d bytes", rd_q.size());
    @(negedge clk);
    clear_mon();
    @(negedge clk);
    reset = 1'b0;
    wait_ack(1'b1, 20, c);
    sd_rd = 1'b0;
    wait_ack(1'b0, 20000, c);
    repeat (3) @(negedge clk);
    $display("[TB] restarted read lba=37 done");
    check_xfer(1'b1, 32'd37, 1'b0);

    for (int k = 0; k < 5; k++) begin
      is_rd = 1'($urandom);
      lba = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MAX_LBA - 1));
      mkey = 8'($urandom); mmask = 8'($urandom); ckey = 8'($urandom);
      run_xfer(is_rd, lba, 1'b1, lba >= 32'(MAX_LBA));
    end

`ifdef SDSRV_WRITE_PROTECT_EN
    wp = 1'b1;
    run_xfer(1'b0, 32'd5, 1'b0, 1'b1);
    wp = 1'b0;
    run_xfer(1'b0, 32'd5, 1'b0, 1'b0);
`endif

    chk("invariants", inv_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
